// File: rtl/spi_tx_pkg.sv
// Shared link types and constants for the board-to-board SPI link.
// Both spi_tx and spi_rx import these so frame timing always agrees.
package spi_tx_pkg;

  localparam int LINK_DATA_WIDTH = 8;
  localparam int LINK_CLK_PERIOD = 4;
  localparam int LINK_GAP_CYCLES = 2;

  typedef logic [LINK_DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_tx_state_t;

  function automatic int half_period(input int period);
    return period / 2;
  endfunction

endpackage

// File: rtl/spi_tx.sv
// SPI mode-0 style transmitter: latches one word on trigger and
// shifts it MSB-first with data clock and active-low select.
module spi_tx
  import spi_tx_pkg::*;
#(
  parameter int DATA_WIDTH      = $bits(data_t),
  parameter int DATA_CLK_PERIOD = LINK_CLK_PERIOD,
  parameter int GAP_CYCLES      = LINK_GAP_CYCLES
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  trigger_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  data_out,
  output logic                  data_clk_out,
  output logic                  sel_out
);

  localparam int H  = half_period(DATA_CLK_PERIOD);
  localparam int HW = $clog2(H + 1);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int GW =
    (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GL =
    (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  localparam logic [HW-1:0] H_LAST = HW'(H - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GL);

  spi_tx_state_t state;
  spi_tx_state_t state_d;

  logic [HW-1:0]         hcnt;
  logic [HW-1:0]         hcnt_d;
  logic [BW-1:0]         bcnt;
  logic [BW-1:0]         bcnt_d;
  logic [GW-1:0]         gcnt;
  logic [GW-1:0]         gcnt_d;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_d;
  logic [DATA_WIDTH-1:0] shifted;

  logic sel_d;
  logic dclk_d;
  logic dout_d;
  logic busy_d;
  logic done_d;

  logic half_end;
  logic bit_end;
  logic gap_end;

  assign half_end = (hcnt == H_LAST);
  assign bit_end  = (bcnt == B_LAST);
  assign gap_end  = (gcnt == G_LAST);
  assign shifted  = shreg << 1;

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state: the data clock phase marks the end of each bit.
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: begin
        if (trigger_in) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (half_end && data_clk_out && bit_end) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (half_end) begin
          state_d = HAS_GAP ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_end) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values; registered below so pins are glitch-free.
  always_comb begin
    hcnt_d  = hcnt;
    bcnt_d  = bcnt;
    gcnt_d  = gcnt;
    shreg_d = shreg;
    sel_d   = sel_out;
    dclk_d  = data_clk_out;
    dout_d  = data_out;
    busy_d  = busy_out;
    done_d  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (trigger_in) begin
          shreg_d = data_in;
          hcnt_d  = '0;
          bcnt_d  = '0;
          gcnt_d  = '0;
          sel_d   = 1'b0;
          dclk_d  = 1'b0;
          dout_d  = data_in[DATA_WIDTH-1];
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!half_end) begin
          hcnt_d = hcnt + 1'b1;
        end else begin
          hcnt_d = '0;
          if (!data_clk_out) begin
            dclk_d = 1'b1;
          end else begin
            dclk_d = 1'b0;
            if (!bit_end) begin
              bcnt_d  = bcnt + 1'b1;
              shreg_d = shifted;
              dout_d  = shifted[DATA_WIDTH-1];
            end
          end
        end
      end
      ST_HOLD: begin
        if (!half_end) begin
          hcnt_d = hcnt + 1'b1;
        end else begin
          hcnt_d  = '0;
          bcnt_d  = '0;
          gcnt_d  = '0;
          shreg_d = '0;
          sel_d   = 1'b1;
          dout_d  = 1'b0;
          done_d  = 1'b1;
          busy_d  = HAS_GAP;
        end
      end
      ST_GAP: begin
        if (gap_end) begin
          gcnt_d = '0;
          busy_d = 1'b0;
        end else begin
          gcnt_d = gcnt + 1'b1;
        end
      end
      default: begin
        sel_d  = 1'b1;
        dclk_d = 1'b0;
        dout_d = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hcnt         <= '0;
      bcnt         <= '0;
      gcnt         <= '0;
      shreg        <= '0;
      sel_out      <= 1'b1;
      data_clk_out <= 1'b0;
      data_out     <= 1'b0;
      busy_out     <= 1'b0;
      done_out     <= 1'b0;
    end else begin
      hcnt         <= hcnt_d;
      bcnt         <= bcnt_d;
      gcnt         <= gcnt_d;
      shreg        <= shreg_d;
      sel_out      <= sel_d;
      data_clk_out <= dclk_d;
      data_out     <= dout_d;
      busy_out     <= busy_d;
      done_out     <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_tx.sv
// Bench for spi_tx: two instances (8b/4/2 and 1b/2/0) checked
// every cycle against a frame-position model, plus literal pins.
module tb_spi_tx;
  import spi_tx_pkg::*;

  localparam int PW [2] = '{8, 1};
  localparam int PP [2] = '{4, 2};
  localparam int PG [2] = '{2, 0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] trig = 2'b00;
  logic [7:0] data_a = 8'h00;
  logic [0:0] data_b = 1'b0;

  logic [1:0] sel;
  logic [1:0] dclk;
  logic [1:0] dout;
  logic [1:0] busy;
  logic [1:0] done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_tx #(
    .DATA_WIDTH(8), .DATA_CLK_PERIOD(4), .GAP_CYCLES(2)
  ) u_a (
    .clk_in(clk), .rst_in(rst_n), .data_in(data_a),
    .trigger_in(trig[0]), .busy_out(busy[0]),
    .done_out(done[0]), .data_out(dout[0]),
    .data_clk_out(dclk[0]), .sel_out(sel[0])
  );

  spi_tx #(
    .DATA_WIDTH(1), .DATA_CLK_PERIOD(2), .GAP_CYCLES(0)
  ) u_b (
    .clk_in(clk), .rst_in(rst_n), .data_in(data_b),
    .trigger_in(trig[1]), .busy_out(busy[1]),
    .done_out(done[1]), .data_out(dout[1]),
    .data_clk_out(dclk[1]), .sel_out(sel[1])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Expected {sel,dclk,dout,busy,done} at position i after accept.
  function automatic logic [4:0] model_out(
    input bit act, input int i, input logic [31:0] w,
    input int W, input int P, input int G);
    int d;
    d = W * P + P / 2;
    if (!act) return 5'b10000;
    if (i < W * P)
      return {1'b0, ((i % P) >= P / 2), w[W-1-i/P], 2'b10};
    if (i < d) return {1'b0, 1'b0, w[0], 2'b10};
    if (i == d) return {3'b100, (G > 0), 1'b1};
    if (i < d + G) return 5'b10010;
    return 5'b10000;
  endfunction

  bit          m_act [2];
  int          m_i [2];
  logic [31:0] m_w [2];
  logic [31:0] din [2];

  always_comb begin
    din[0] = 32'(data_a);
    din[1] = 32'(data_b);
  end

  // Frame-position model: busy is 0 from position D+G onward.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      int d;
      d = PW[k] * PP[k] + PP[k] / 2;
      if (!rst_n) begin
        m_act[k] <= 1'b0;
        m_i[k] <= 0;
      end else if ((!m_act[k] || m_i[k] >= d + PG[k]) && trig[k]) begin
        m_act[k] <= 1'b1;
        m_i[k] <= 0;
        m_w[k] <= din[k];
      end else if (m_act[k]) begin
        if (m_i[k] >= d + PG[k] && m_i[k] > d) m_act[k] <= 1'b0;
        else m_i[k] <= m_i[k] + 1;
      end
    end
  end

  int          flen_cur [2] = '{0, 0};
  int          flen_last [2] = '{0, 0};
  logic [31:0] fbits_cur [2] = '{0, 0};
  logic [31:0] fbits_last [2] = '{0, 0};
  int          gap_cur [2] = '{0, 0};
  int          gap_last [2] = '{0, 0};
  int          busy_cur [2] = '{0, 0};
  int          busy_last [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  int          done_busy [2] = '{0, 0};
  int          fstart [2] = '{0, 0};
  logic        p_sel [2] = '{1'b1, 1'b1};
  logic        p_clk [2] = '{1'b0, 1'b0};
  logic        p_busy [2] = '{1'b0, 1'b0};

  // Compare and monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        logic [4:0] exp;
        exp = model_out(m_act[k], m_i[k], m_w[k],
                        PW[k], PP[k], PG[k]);
        chk(k == 0 ? "model_a" : "model_b",
            {27'b0, sel[k], dclk[k], dout[k], busy[k], done[k]},
            {27'b0, exp});
        if (!sel[k]) begin
          if (p_sel[k]) begin
            flen_cur[k] = 0;
            fbits_cur[k] = 0;
            gap_last[k] = gap_cur[k];
            fstart[k]++;
          end
          flen_cur[k]++;
          if (dclk[k] && !p_clk[k])
            fbits_cur[k] = {fbits_cur[k][30:0], dout[k]};
        end else begin
          if (!p_sel[k]) begin
            flen_last[k] = flen_cur[k];
            fbits_last[k] = fbits_cur[k];
            gap_cur[k] = 0;
          end
          gap_cur[k]++;
        end
        if (busy[k]) busy_cur[k]++;
        else if (p_busy[k]) begin
          busy_last[k] = busy_cur[k];
          busy_cur[k] = 0;
        end
        if (done[k]) done_cnt[k]++;
        if (done[k] && busy[k]) done_busy[k]++;
        p_sel[k] = sel[k];
        p_clk[k] = dclk[k];
        p_busy[k] = busy[k];
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int d0;
  int s0;

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("reset_a", {27'b0, sel[0], dclk[0], dout[0],
        busy[0], done[0]}, 32'h10);
    chk("reset_b", {27'b0, sel[1], dclk[1], dout[1],
        busy[1], done[1]}, 32'h10);
    step(3);
    rst_n = 1'b1;
    step(2);

    d0 = done_cnt[0];
    data_a = 8'hA5;
    trig[0] = 1'b1;
    step(1);
    trig[0] = 1'b0;
    data_a = 8'($urandom);
    step(42);
    chk("a5_len", flen_last[0], 34);
    chk("a5_bits", fbits_last[0], 32'hA5);
    chk("a5_done", done_cnt[0] - d0, 1);
    chk("a5_busy", busy_last[0], 36);

    d0 = done_cnt[0];
    s0 = fstart[0];
    data_a = 8'h01;
    trig[0] = 1'b1;
    step(120);
    trig[0] = 1'b0;
    step(42);
    chk("b2b_gap", gap_last[0], 3);
    chk("b2b_bits", fbits_last[0], 32'h01);
    chk("b2b_frames", fstart[0] - s0, 4);
    chk("b2b_done", done_cnt[0] - d0, fstart[0] - s0);

    d0 = done_cnt[0];
    s0 = fstart[0];
    data_a = 8'h3C;
    trig[0] = 1'b1;
    step(1);
    trig[0] = 1'b0;
    step(9);
    data_a = 8'h00;
    trig[0] = 1'b1;
    step(1);
    trig[0] = 1'b0;
    step(40);
    chk("ign_bits", fbits_last[0], 32'h3C);
    chk("ign_done", done_cnt[0] - d0, 1);
    chk("ign_frames", fstart[0] - s0, 1);

    d0 = done_cnt[0];
    data_a = 8'hC3;
    trig[0] = 1'b1;
    step(1);
    trig[0] = 1'b0;
    step(11);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid", {27'b0, sel[0], dclk[0], dout[0],
        busy[0], done[0]}, 32'h10);
    step(1);
    rst_n = 1'b1;
    step(40);
    chk("rst_nodone", done_cnt[0] - d0, 0);
    data_a = 8'h5A;
    trig[0] = 1'b1;
    step(1);
    trig[0] = 1'b0;
    step(42);
    chk("post_rst_bits", fbits_last[0], 32'h5A);
    chk("post_rst_len", flen_last[0], 34);

    d0 = done_cnt[1];
    data_b = 1'b1;
    trig[1] = 1'b1;
    step(1);
    trig[1] = 1'b0;
    step(6);
    chk("w1_len", flen_last[1], 3);
    chk("w1_bits", fbits_last[1], 32'h1);
    chk("w1_busy", busy_last[1], 3);
    chk("w1_done", done_cnt[1] - d0, 1);
    chk("w1_coincide", done_busy[1], 0);

    data_b = 1'b0;
    trig[1] = 1'b1;
    step(12);
    trig[1] = 1'b0;
    step(4);
    chk("w1_gap", gap_last[1], 1);

    for (int n = 0; n < 600; n++) begin
      trig[0] = ($urandom_range(0, 5) == 0);
      trig[1] = ($urandom_range(0, 2) == 0);
      data_a = 8'($urandom);
      data_b = 1'($urandom);
      step(1);
    end
    trig = 2'b00;
    step(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
